// File: rtl/gpu_instruction_loader.sv
// Write-side front end for gpu_instruction_fifo: assembles three 32-bit host
// command words into one draw instruction and pushes it when the FIFO has room.

`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_instruction_loader #(
    parameter logic [3:0]  MAX_OPCODE = 4'd7,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [31:0]               cmd_data_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      abort_i,
    input  logic                      clear_err_i,
    input  logic                      fifo_full_i,
    output logic [3:0]                opcode_o,
    output logic [`WIDTH_BITS-1:0]    x1_o,
    output logic [`HEIGHT_BITS-1:0]   y1_o,
    output logic [`WIDTH_BITS-1:0]    x2_o,
    output logic [`HEIGHT_BITS-1:0]   y2_o,
    output logic [`WIDTH_BITS-1:0]    rad_o,
    output logic [`CHANNEL_BITS-1:0]  r_o,
    output logic [`CHANNEL_BITS-1:0]  g_o,
    output logic [`CHANNEL_BITS-1:0]  b_o,
    output logic [2:0]                oct_o,
    output logic                      write_enable_o,
    output logic                      push_instruction_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [CNT_BITS-1:0]       instr_count_o
);

    localparam int unsigned WB = `WIDTH_BITS;
    localparam int unsigned HB = `HEIGHT_BITS;
    localparam int unsigned CB = `CHANNEL_BITS;

    localparam logic [1:0] S_W0   = 2'd0;
    localparam logic [1:0] S_W1   = 2'd1;
    localparam logic [1:0] S_W2   = 2'd2;
    localparam logic [1:0] S_PUSH = 2'd3;

    logic [1:0]          state_q, state_d;
    logic                invalid_q, invalid_d;
    logic                err_q, err_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                accept;
    logic                cap0, cap1, cap2, push;

    logic [3:0]    opcode_q;
    logic [WB-1:0] x1_q, x2_q, rad_q;
    logic [HB-1:0] y1_q, y2_q;
    logic [CB-1:0] r_q, g_q, b_q;
    logic [2:0]    oct_q;

    // Top command bits carry no field in any word.
    logic unused_hi;
    assign unused_hi = ^cmd_data_i[31:29];

    assign accept = cmd_valid_i && (state_q != S_PUSH);

    // Next-state, capture enables and push strobe; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        invalid_d = invalid_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        cap0      = 1'b0;
        cap1      = 1'b0;
        cap2      = 1'b0;
        push      = 1'b0;

        if (clear_err_i) begin
            err_d = 1'b0;
        end

        if (abort_i) begin
            state_d   = S_W0;
            invalid_d = 1'b0;
        end else begin
            case (state_q)
                S_W0: begin
                    if (accept) begin
                        cap0      = 1'b1;
                        invalid_d = (cmd_data_i[3:0] > MAX_OPCODE);
                        state_d   = S_W1;
                    end
                end
                S_W1: begin
                    if (accept) begin
                        cap1    = 1'b1;
                        state_d = S_W2;
                    end
                end
                S_W2: begin
                    if (accept) begin
                        cap2 = 1'b1;
                        if (invalid_q) begin
                            err_d     = 1'b1;
                            invalid_d = 1'b0;
                            state_d   = S_W0;
                        end else begin
                            state_d = S_PUSH;
                        end
                    end
                end
                S_PUSH: begin
                    if (!fifo_full_i) begin
                        push    = 1'b1;
                        cnt_d   = cnt_q + CNT_BITS'(1);
                        state_d = S_W0;
                    end
                end
                default: state_d = S_W0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_W0;
            invalid_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            invalid_q <= invalid_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Field registers load only on their word's capture and hold otherwise.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            opcode_q <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            oct_q    <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            rad_q    <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            if (cap0) begin
                opcode_q <= cmd_data_i[3:0];
                x1_q     <= cmd_data_i[13:4];
                y1_q     <= cmd_data_i[22:14];
                oct_q    <= cmd_data_i[25:23];
            end
            if (cap1) begin
                x2_q  <= cmd_data_i[9:0];
                y2_q  <= cmd_data_i[18:10];
                rad_q <= cmd_data_i[28:19];
            end
            if (cap2) begin
                r_q <= cmd_data_i[7:0];
                g_q <= cmd_data_i[15:8];
                b_q <= cmd_data_i[23:16];
            end
        end
    end

    assign cmd_ready_o        = (state_q != S_PUSH);
    assign busy_o             = (state_q != S_W0);
    assign write_enable_o     = push;
    assign push_instruction_o = push;
    assign err_o              = err_q;
    assign instr_count_o      = cnt_q;

    assign opcode_o = opcode_q;
    assign x1_o     = x1_q;
    assign y1_o     = y1_q;
    assign oct_o    = oct_q;
    assign x2_o     = x2_q;
    assign y2_o     = y2_q;
    assign rad_o    = rad_q;
    assign r_o      = r_q;
    assign g_o      = g_q;
    assign b_o      = b_q;

endmodule

// File: tb/tb_gpu_instruction_loader.sv
// Directed bench for gpu_instruction_loader: per-cycle vector table plus
// hand sequences for counter wrap and mid-instruction reset.

module tb_gpu_instruction_loader;

    typedef struct packed {
        logic [3:0] op;
        logic [9:0] x1;
        logic [8:0] y1;
        logic [2:0] oct;
        logic [9:0] x2;
        logic [8:0] y2;
        logic [9:0] rad;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } ins_t;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        ab;
        logic        cl;
        logic        fu;
        logic        rd;
        logic        bz;
        logic        we;
        logic        er;
        logic [15:0] c;
        int          f;
    } vec_t;

    localparam logic [31:0] A0 = 32'h00A0_2453;
    localparam logic [31:0] A1 = 32'h0E03_20C8;
    localparam logic [31:0] A2 = 32'h0030_2010;

    logic        clk;
    logic        n_rst;
    logic [31:0] cmd_data_i;
    logic        cmd_valid_i;
    logic        abort_i;
    logic        clear_err_i;
    logic        fifo_full_i;

    logic        cmd_ready_o, write_enable_o, push_instruction_o, busy_o, err_o;
    logic [3:0]  opcode_o;
    logic [9:0]  x1_o, x2_o, rad_o;
    logic [8:0]  y1_o, y2_o;
    logic [7:0]  r_o, g_o, b_o;
    logic [2:0]  oct_o;
    logic [15:0] instr_count_o;

    logic        n_ready, n_we, n_push, n_busy, n_err;
    logic [3:0]  n_opcode;
    logic [9:0]  n_x1, n_x2, n_rad;
    logic [8:0]  n_y1, n_y2;
    logic [7:0]  n_r, n_g, n_b;
    logic [2:0]  n_oct;
    logic [3:0]  n_cnt;

    logic [78:0] fields;
    assign fields = {opcode_o, x1_o, y1_o, oct_o, x2_o, y2_o, rad_o, r_o, g_o, b_o};

    int   n_cmp;
    int   n_fail;
    ins_t exp_ins [5];
    vec_t tbl [$];

    gpu_instruction_loader u_dut (
        .clk(clk), .n_rst(n_rst),
        .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .abort_i(abort_i), .clear_err_i(clear_err_i), .fifo_full_i(fifo_full_i),
        .opcode_o(opcode_o), .x1_o(x1_o), .y1_o(y1_o), .x2_o(x2_o), .y2_o(y2_o),
        .rad_o(rad_o), .r_o(r_o), .g_o(g_o), .b_o(b_o), .oct_o(oct_o),
        .write_enable_o(write_enable_o), .push_instruction_o(push_instruction_o),
        .busy_o(busy_o), .err_o(err_o), .instr_count_o(instr_count_o)
    );

    // Narrow-counter copy on the same stimulus, so the wrap is reachable quickly.
    gpu_instruction_loader #(.CNT_BITS(4)) u_dut_narrow (
        .clk(clk), .n_rst(n_rst),
        .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(n_ready),
        .abort_i(abort_i), .clear_err_i(clear_err_i), .fifo_full_i(fifo_full_i),
        .opcode_o(n_opcode), .x1_o(n_x1), .y1_o(n_y1), .x2_o(n_x2), .y2_o(n_y2),
        .rad_o(n_rad), .r_o(n_r), .g_o(n_g), .b_o(n_b), .oct_o(n_oct),
        .write_enable_o(n_we), .push_instruction_o(n_push),
        .busy_o(n_busy), .err_o(n_err), .instr_count_o(n_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc0(input ins_t i);
        return {6'd0, i.oct, i.y1, i.x1, i.op};
    endfunction
    function automatic logic [31:0] enc1(input ins_t i);
        return {3'd0, i.rad, i.y2, i.x2};
    endfunction
    function automatic logic [31:0] enc2(input ins_t i);
        return {8'd0, i.b, i.g, i.r};
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic v, input logic [31:0] d, input logic ab, input logic cl,
                           input logic fu, input logic rd, input logic bz, input logic we,
                           input logic er, input logic [15:0] c, input int f);
        vec_t t;
        t.v = v; t.d = d; t.ab = ab; t.cl = cl; t.fu = fu;
        t.rd = rd; t.bz = bz; t.we = we; t.er = er; t.c = c; t.f = f;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        @(negedge clk);
        cmd_valid_i = v;
        cmd_data_i  = d;
        abort_i     = 1'b0;
        clear_err_i = 1'b0;
        fifo_full_i = 1'b0;
    endtask

    task automatic run_row(input int idx, input vec_t t);
        @(negedge clk);
        cmd_valid_i = t.v;
        cmd_data_i  = t.d;
        abort_i     = t.ab;
        clear_err_i = t.cl;
        fifo_full_i = t.fu;
        #1;
        chk($sformatf("row%0d ready", idx), 96'(cmd_ready_o), 96'(t.rd));
        chk($sformatf("row%0d busy", idx), 96'(busy_o), 96'(t.bz));
        chk($sformatf("row%0d write_enable", idx), 96'(write_enable_o), 96'(t.we));
        chk($sformatf("row%0d push", idx), 96'(push_instruction_o), 96'(t.we));
        chk($sformatf("row%0d err", idx), 96'(err_o), 96'(t.er));
        chk($sformatf("row%0d count", idx), 96'(instr_count_o), 96'(t.c));
        chk($sformatf("row%0d count_narrow", idx), 96'(n_cnt), 96'(t.c[3:0]));
        if (t.f >= 0) begin
            chk($sformatf("row%0d fields", idx), 96'(fields), 96'(exp_ins[t.f]));
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        exp_ins[0] = '{op:4'd3, x1:10'h245, y1:9'h080, oct:3'd1, x2:10'h0C8, y2:9'h0C8,
                       rad:10'h1C0, r:8'h10, g:8'h20, b:8'h30};
        exp_ins[1] = '{op:4'd5, x1:10'h3FF, y1:9'h1FF, oct:3'd7, x2:10'h000, y2:9'h1FF,
                       rad:10'h3FF, r:8'hFF, g:8'h00, b:8'hA5};
        exp_ins[2] = '{op:4'd0, x1:10'h001, y1:9'h002, oct:3'd3, x2:10'h004, y2:9'h005,
                       rad:10'h006, r:8'h07, g:8'h08, b:8'h09};
        exp_ins[3] = '{op:4'd7, x1:10'h2AA, y1:9'h155, oct:3'd5, x2:10'h155, y2:9'h0AA,
                       rad:10'h2AA, r:8'h5A, g:8'hA5, b:8'hC3};
        exp_ins[4] = '{op:4'd6, x1:10'h100, y1:9'h100, oct:3'd2, x2:10'h200, y2:9'h0FF,
                       rad:10'h001, r:8'h01, g:8'h02, b:8'h03};

        // Basic instruction A, FIFO not full.
        add_vec(1, A0, 0, 0, 0, 1, 0, 0, 0, 0, -1);
        add_vec(1, A1, 0, 0, 0, 1, 1, 0, 0, 0, -1);
        add_vec(1, A2, 0, 0, 0, 1, 1, 0, 0, 0, -1);
        add_vec(0, 0,  0, 0, 0, 0, 1, 1, 0, 0, 0);
        add_vec(0, 0,  0, 0, 0, 1, 0, 0, 0, 1, 0);
        // Instruction B stalled by a full FIFO for five cycles.
        add_vec(1, enc0(exp_ins[1]), 0, 0, 0, 1, 0, 0, 0, 1, -1);
        add_vec(1, enc1(exp_ins[1]), 0, 0, 0, 1, 1, 0, 0, 1, -1);
        add_vec(1, enc2(exp_ins[1]), 0, 0, 1, 1, 1, 0, 0, 1, -1);
        for (int i = 0; i < 5; i++) add_vec(1, 32'hFFFF_FFFF, 0, 0, 1, 0, 1, 0, 0, 1, 1);
        add_vec(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
        add_vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 1);
        // Opcode 0xF dropped, then a valid push with err held, then clear.
        add_vec(1, 32'h0000_000F, 0, 0, 0, 1, 0, 0, 0, 2, -1);
        add_vec(1, 32'h1234_5678, 0, 0, 0, 1, 1, 0, 0, 2, -1);
        add_vec(1, 32'h9ABC_DEF0, 0, 0, 0, 1, 1, 0, 0, 2, -1);
        add_vec(0, 0,  0, 0, 0, 1, 0, 0, 1, 2, -1);
        add_vec(1, A0, 0, 0, 0, 1, 0, 0, 1, 2, -1);
        add_vec(1, A1, 0, 0, 0, 1, 1, 0, 1, 2, -1);
        add_vec(1, A2, 0, 0, 0, 1, 1, 0, 1, 2, -1);
        add_vec(0, 0,  0, 0, 0, 0, 1, 1, 1, 2, 0);
        add_vec(0, 0,  0, 1, 0, 1, 0, 0, 1, 3, 0);
        add_vec(0, 0,  0, 0, 0, 1, 0, 0, 0, 3, -1);
        // Opcode 8 (one past the max) with clear in the same cycle: set wins.
        add_vec(1, 32'h0000_0008, 0, 0, 0, 1, 0, 0, 0, 3, -1);
        add_vec(1, 0, 0, 0, 0, 1, 1, 0, 0, 3, -1);
        add_vec(1, 0, 0, 1, 0, 1, 1, 0, 0, 3, -1);
        add_vec(0, 0, 0, 0, 0, 1, 0, 0, 1, 3, -1);
        add_vec(0, 0, 0, 1, 0, 1, 0, 0, 1, 3, -1);
        add_vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 3, -1);
        // Abort in W2 with a word offered: discarded; next three words push once.
        add_vec(1, A0, 0, 0, 0, 1, 0, 0, 0, 3, -1);
        add_vec(1, A1, 0, 0, 0, 1, 1, 0, 0, 3, -1);
        add_vec(1, A2, 1, 0, 0, 1, 1, 0, 0, 3, -1);
        add_vec(0, 0,  0, 0, 0, 1, 0, 0, 0, 3, -1);
        add_vec(1, enc0(exp_ins[1]), 0, 0, 0, 1, 0, 0, 0, 3, -1);
        add_vec(1, enc1(exp_ins[1]), 0, 0, 0, 1, 1, 0, 0, 3, -1);
        add_vec(1, enc2(exp_ins[1]), 0, 0, 0, 1, 1, 0, 0, 3, -1);
        add_vec(0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 1);
        add_vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 4, 1);
        // Abort in PUSH with FIFO not full: no push.
        add_vec(1, A0, 0, 0, 0, 1, 0, 0, 0, 4, -1);
        add_vec(1, A1, 0, 0, 0, 1, 1, 0, 0, 4, -1);
        add_vec(1, A2, 0, 0, 0, 1, 1, 0, 0, 4, -1);
        add_vec(0, 0,  1, 0, 0, 0, 1, 0, 0, 4, 0);
        add_vec(0, 0,  0, 0, 0, 1, 0, 0, 0, 4, 0);
        // Abort after an invalid W0 clears the marker; next instruction pushes.
        add_vec(1, 32'h0000_000F, 0, 0, 0, 1, 0, 0, 0, 4, -1);
        add_vec(0, 0,  1, 0, 0, 1, 1, 0, 0, 4, -1);
        add_vec(0, 0,  0, 0, 0, 1, 0, 0, 0, 4, -1);
        add_vec(1, A0, 0, 0, 0, 1, 0, 0, 0, 4, -1);
        add_vec(1, A1, 0, 0, 0, 1, 1, 0, 0, 4, -1);
        add_vec(1, A2, 0, 0, 0, 1, 1, 0, 0, 4, -1);
        add_vec(0, 0,  0, 0, 0, 0, 1, 1, 0, 4, 0);
        add_vec(0, 0,  0, 0, 0, 1, 0, 0, 0, 5, 0);
        // Valid toggled every other cycle across nine words (C, D, E).
        for (int j = 2; j < 5; j++) begin
            add_vec(1, enc0(exp_ins[j]), 0, 0, 0, 1, 0, 0, 0, 16'(3 + j), -1);
            add_vec(0, 0,                0, 0, 0, 1, 1, 0, 0, 16'(3 + j), -1);
            add_vec(1, enc1(exp_ins[j]), 0, 0, 0, 1, 1, 0, 0, 16'(3 + j), -1);
            add_vec(0, 0,                0, 0, 0, 1, 1, 0, 0, 16'(3 + j), -1);
            add_vec(1, enc2(exp_ins[j]), 0, 0, 0, 1, 1, 0, 0, 16'(3 + j), -1);
            add_vec(0, 0,                0, 0, 0, 0, 1, 1, 0, 16'(3 + j), j);
        end
        add_vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 4);

        n_rst       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_data_i  = '0;
        abort_i     = 1'b0;
        clear_err_i = 1'b0;
        fifo_full_i = 1'b0;
        #3;
        chk("reset ready", 96'(cmd_ready_o), 96'(1));
        chk("reset busy", 96'(busy_o), 96'(0));
        chk("reset strobes", 96'({write_enable_o, push_instruction_o}), 96'(0));
        chk("reset err", 96'(err_o), 96'(0));
        chk("reset count", 96'(instr_count_o), 96'(0));
        chk("reset fields", 96'(fields), 96'(0));
        @(negedge clk);
        n_rst = 1'b1;

        foreach (tbl[i]) run_row(i, tbl[i]);

        // Eight more back-to-back pushes take the narrow counter through 15 -> 0.
        for (int k = 0; k < 8; k++) begin
            drive(1, A0);
            drive(1, A1);
            drive(1, A2);
            drive(0, 0);
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d count", k), 96'(instr_count_o), 96'(9 + k));
            chk($sformatf("wrap%0d count_narrow", k), 96'(n_cnt), 96'((9 + k) % 16));
        end

        // Set err, stop in W2, then reset: everything returns to reset values.
        drive(1, 32'h0000_000F);
        drive(1, 0);
        drive(1, 0);
        drive(1, A0);
        #1;
        chk("pre_reset err", 96'(err_o), 96'(1));
        drive(1, A1);
        drive(1, A2);
        #1;
        chk("pre_reset busy", 96'(busy_o), 96'(1));
        n_rst = 1'b0;
        #1;
        chk("midreset busy", 96'(busy_o), 96'(0));
        chk("midreset ready", 96'(cmd_ready_o), 96'(1));
        chk("midreset strobes", 96'({write_enable_o, push_instruction_o}), 96'(0));
        chk("midreset err", 96'(err_o), 96'(0));
        chk("midreset count", 96'(instr_count_o), 96'(0));
        chk("midreset fields", 96'(fields), 96'(0));
        @(posedge clk);
        #1;
        chk("reset_hold strobes", 96'({write_enable_o, push_instruction_o}), 96'(0));
        chk("reset_hold busy", 96'(busy_o), 96'(0));
        drive(0, 0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset strobes", 96'({write_enable_o, push_instruction_o}), 96'(0));
        chk("post_reset busy", 96'(busy_o), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gpu_instruction_loader.md
Name: gpu_instruction_loader

Overview:
- Write-side companion to gpu_instruction_fifo.
- Accepts 32-bit command words from the host bus over a valid/ready handshake and assembles them into one full draw instruction (opcode, coordinates, radius, colour, octant).
- Pushes each completed instruction into the instruction FIFO, stalling while the FIFO reports full.
- Drops malformed instructions and flags them with a sticky error.

Parameters:
- MAX_OPCODE, 4'd7, highest legal opcode; any larger opcode is invalid.
- CNT_BITS, 16, width of the pushed-instruction counter.

Ports:
- clk  input  1  clock
- n_rst  input  1  asynchronous active-low reset
- cmd_data_i  input  32  command word
- cmd_valid_i  input  1  cmd_data_i valid
- cmd_ready_o  output  1  loader accepts word this cycle
- abort_i  input  1  synchronous discard of partial instruction
- clear_err_i  input  1  synchronous clear of err_o
- fifo_full_i  input  1  FIFO full flag
- opcode_o  output  4  instruction opcode to FIFO
- x1_o  output  `WIDTH_BITS  to FIFO
- y1_o  output  `HEIGHT_BITS  to FIFO
- x2_o  output  `WIDTH_BITS  to FIFO
- y2_o  output  `HEIGHT_BITS  to FIFO
- rad_o  output  `WIDTH_BITS  to FIFO
- r_o  output  `CHANNEL_BITS  to FIFO
- g_o  output  `CHANNEL_BITS  to FIFO
- b_o  output  `CHANNEL_BITS  to FIFO
- oct_o  output  3  to FIFO
- write_enable_o  output  1  FIFO data write strobe
- push_instruction_o  output  1  FIFO pointer advance strobe
- busy_o  output  1  partial or pending instruction held
- err_o  output  1  sticky invalid-opcode flag
- instr_count_o  output  CNT_BITS  instructions pushed, wraps

Behaviour:

Reset and interface basics
- Reset is n_rst, asynchronous, active-low. Clock is clk.
- On reset: state W0, all field outputs 0, strobes 0, busy_o 0, err_o 0, instr_count_o 0.
- A word transfers on any rising edge with cmd_valid_i && cmd_ready_o.

Word format (field widths 10/9/8)
- W0: [3:0] opcode, [13:4] x1, [22:14] y1, [25:23] oct, [31:26] ignored.
- W1: [9:0] x2, [18:10] y2, [28:19] rad, [31:29] ignored.
- W2: [7:0] r, [15:8] g, [23:16] b, [31:24] ignored.

FSM states: W0, W1, W2, PUSH
- W0 (ready=1): on transfer, capture W0 fields into output registers.
  - If opcode > MAX_OPCODE: set invalid marker.
  - Go to W1.
- W1 (ready=1): on transfer, capture W1 fields, go to W2.
- W2 (ready=1): on transfer, capture W2 fields.
  - Invalid marker set: set err_o, clear marker, go to W0. No push.
  - Otherwise: go to PUSH.
- PUSH (ready=0):
  - If !fifo_full_i: assert write_enable_o and push_instruction_o together for exactly that cycle, increment instr_count_o, go to W0.
  - Else hold in PUSH with strobes low, for unbounded cycles.

Timing and data stability
- Strobes are combinational from (state==PUSH && !fifo_full_i). Fields are registered and stable through the whole PUSH state.
- Latency: third word accepted at edge N → push strobes high in cycle N..N+1 when not full.
- Minimum 4 cycles per instruction. No word is accepted during PUSH.
- Field registers update only on capture. They hold their last value otherwise, so outputs stay stable after the push.

Status outputs
- busy_o = 1 in W1, W2, PUSH; 0 in W0.
- err_o: set by an invalid instruction, cleared by clear_err_i. Set wins if both occur in the same cycle.
- instr_count_o wraps from 2^CNT_BITS-1 to 0.

Abort
- abort_i has priority over every transition.
- Returns to W0 and clears the invalid marker. No push occurs, even in PUSH with FIFO not full.
- cmd_ready_o stays as defined by the current state, but a word transferred in the abort cycle is discarded.
- Field registers are not cleared.

Reset mid-instruction
- Discards everything. The FIFO sees no strobe.

Test Plan:
- Reset, then words 0x00A0_2453, 0x0E03_20C8, 0x0030_2010 with FIFO not full:
  - Required fields: opcode=3, x1=0x245, y1=0x080, oct=1, x2=0xC8, y2=0xC8, rad=0x1C0, r=0x10, g=0x20, b=0x30.
  - Single-cycle write_enable_o and push_instruction_o one cycle after the third accept; instr_count_o=1.
- Same instruction with fifo_full_i=1 for 5 cycles:
  - Loader holds PUSH, cmd_ready_o=0, strobes 0, fields stable.
  - Push occurs in the cycle fifo_full_i falls.
- W0 opcode 0xF, then two words:
  - No push, err_o=1, busy_o=0 after the third word.
  - A subsequent valid instruction pushes normally while err_o remains 1.
  - clear_err_i → err_o=0.
- abort_i after two words:
  - busy_o=0 next cycle.
  - The next three words form one complete instruction; exactly one push.
- cmd_valid_i toggled every other cycle across 9 words:
  - Exactly 3 pushes with correct field grouping.
  - instr_count_o preset to 0xFFFF via a count of 65535 pushes in a fast sim: wraps to 0.
- n_rst asserted while in W2: all outputs return to reset values immediately; no strobe.
